biriscv_branch_predictor: RTL and testbench



---
 rtl/biriscv_branch_predictor.sv | 170 +++++++++++++++++
 tb/tb_biriscv_branch_predictor.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/biriscv_branch_predictor.sv
// rtl/biriscv_branch_predictor.sv - direct-mapped BTB, 2-bit BHT and return address stack next-PC predictor
// Optional BP_RAS_SPEC_EN: fetch-time speculative RAS with recovery to the resolution-side copy.
module biriscv_branch_predictor #(
    parameter int NUM_BTB_ENTRIES = 16,
    parameter int NUM_BHT_ENTRIES = 64,
    parameter int NUM_RAS_ENTRIES = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        branch_request_i,
    input  logic        branch_is_taken_i,
    input  logic        branch_is_not_taken_i,
    input  logic [31:0] branch_source_i,
    input  logic [31:0] branch_pc_i,
    input  logic        branch_is_call_i,
    input  logic        branch_is_ret_i,
    input  logic        branch_is_jmp_i,
    input  logic [31:0] pc_f_i,
    input  logic        pc_accept_i,
    output logic [31:0] next_pc_f_o,
    output logic        next_taken_f_o
);
    localparam int BTB_W = $clog2(NUM_BTB_ENTRIES);
    localparam int BHT_W = $clog2(NUM_BHT_ENTRIES);
    localparam int RAS_W = $clog2(NUM_RAS_ENTRIES);
    localparam int TAG_W = 30 - BTB_W;
    localparam logic [RAS_W-1:0] PTR_ONE  = RAS_W'(1);
    localparam logic [RAS_W:0]   CNT_ONE  = (RAS_W+1)'(1);
    localparam logic [RAS_W:0]   CNT_FULL = (RAS_W+1)'(NUM_RAS_ENTRIES);

    typedef struct packed {
        logic [RAS_W-1:0] ptr;
        logic [RAS_W:0]   count;
        logic             wr;
        logic [RAS_W-1:0] wr_idx;
    } ras_step_t;

    // ptr is the next write slot, so the top lives at ptr-1; pop-then-push rewrites the top in place.
    function automatic ras_step_t ras_step(input logic [RAS_W-1:0] ptr, input logic [RAS_W:0] count,
                                           input logic push, input logic pop);
        ras_step_t s;
        s.ptr    = ptr;
        s.count  = count;
        s.wr     = 1'b0;
        s.wr_idx = ptr;
        if (push && pop && count != '0) begin
            s.wr     = 1'b1;
            s.wr_idx = ptr - PTR_ONE;
        end else if (push) begin
            s.wr  = 1'b1;
            s.ptr = ptr + PTR_ONE;
            if (count != CNT_FULL) s.count = count + CNT_ONE;
        end else if (pop && count != '0) begin
            s.ptr   = ptr - PTR_ONE;
            s.count = count - CNT_ONE;
        end
        return s;
    endfunction

    logic             btb_valid_q  [NUM_BTB_ENTRIES];
    logic [TAG_W-1:0] btb_tag_q    [NUM_BTB_ENTRIES];
    logic [31:0]      btb_target_q [NUM_BTB_ENTRIES];
    logic             btb_call_q   [NUM_BTB_ENTRIES];
    logic             btb_ret_q    [NUM_BTB_ENTRIES];
    logic             btb_jmp_q    [NUM_BTB_ENTRIES];
    logic [1:0]       bht_q        [NUM_BHT_ENTRIES];
    logic [31:0]      ras_q        [NUM_RAS_ENTRIES];
    logic [RAS_W-1:0] ras_ptr_q;
    logic [RAS_W:0]   ras_count_q;

    logic             upd_valid;
    logic [BTB_W-1:0] upd_btb_idx, f_btb_idx;
    logic [BHT_W-1:0] upd_bht_idx, f_bht_idx;
    logic [TAG_W-1:0] upd_tag, f_tag;
    logic             f_hit;
    logic [RAS_W-1:0] ras_top_ptr;
    logic             ras_empty;
    ras_step_t        res_step;
    logic [4:0]       unused_bits;

    // Contradictory or direction-less resolutions are dropped completely.
    assign upd_valid   = branch_request_i & (branch_is_taken_i ^ branch_is_not_taken_i);
    assign upd_btb_idx = branch_source_i[BTB_W+1:2];
    assign upd_bht_idx = branch_source_i[BHT_W+1:2];
    assign upd_tag     = branch_source_i[31:BTB_W+2];
    assign f_btb_idx   = pc_f_i[BTB_W+1:2];
    assign f_bht_idx   = pc_f_i[BHT_W+1:2];
    assign f_tag       = pc_f_i[31:BTB_W+2];
    assign f_hit       = btb_valid_q[f_btb_idx] && (btb_tag_q[f_btb_idx] == f_tag);
    assign res_step    = ras_step(ras_ptr_q, ras_count_q, upd_valid & branch_is_call_i,
                                  upd_valid & branch_is_ret_i);
    assign unused_bits = {pc_accept_i, pc_f_i[1:0], branch_source_i[1:0]};

`ifdef BP_RAS_SPEC_EN
    logic [RAS_W-1:0] spec_ptr_q;
    logic [RAS_W:0]   spec_count_q;
    logic             upd_hit;
    logic             upd_mispredict;
    ras_step_t        spec_step;

    // A resolved call/ret that fetch could not have predicted with the same class resyncs the speculative copy.
    assign upd_hit        = btb_valid_q[upd_btb_idx] && (btb_tag_q[upd_btb_idx] == upd_tag);
    assign upd_mispredict = upd_valid && (branch_is_call_i || branch_is_ret_i) &&
                            !(upd_hit && btb_call_q[upd_btb_idx] == branch_is_call_i &&
                              btb_ret_q[upd_btb_idx] == branch_is_ret_i);
    assign spec_step      = ras_step(spec_ptr_q, spec_count_q,
                                     pc_accept_i & f_hit & btb_call_q[f_btb_idx],
                                     pc_accept_i & f_hit & btb_ret_q[f_btb_idx]);
    assign ras_top_ptr    = spec_ptr_q - PTR_ONE;
    assign ras_empty      = (spec_count_q == '0);
`else
    assign ras_top_ptr    = ras_ptr_q - PTR_ONE;
    assign ras_empty      = (ras_count_q == '0);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_BTB_ENTRIES; i++) btb_valid_q[i] <= 1'b0;
            for (int i = 0; i < NUM_BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
            ras_ptr_q   <= '0;
            ras_count_q <= '0;
`ifdef BP_RAS_SPEC_EN
            spec_ptr_q   <= '0;
            spec_count_q <= '0;
`endif
        end else begin
            if (upd_valid) begin
                if (branch_is_taken_i) begin
                    if (bht_q[upd_bht_idx] != 2'b11) bht_q[upd_bht_idx] <= bht_q[upd_bht_idx] + 2'b01;
                    btb_valid_q[upd_btb_idx]  <= 1'b1;
                    btb_tag_q[upd_btb_idx]    <= upd_tag;
                    btb_target_q[upd_btb_idx] <= branch_pc_i;
                    btb_call_q[upd_btb_idx]   <= branch_is_call_i;
                    btb_ret_q[upd_btb_idx]    <= branch_is_ret_i;
                    btb_jmp_q[upd_btb_idx]    <= branch_is_jmp_i;
                end else if (bht_q[upd_bht_idx] != 2'b00) begin
                    bht_q[upd_bht_idx] <= bht_q[upd_bht_idx] - 2'b01;
                end
            end
`ifdef BP_RAS_SPEC_EN
            if (spec_step.wr) ras_q[spec_step.wr_idx] <= pc_f_i + 32'd4;
            if (upd_mispredict) begin
                spec_ptr_q   <= res_step.ptr;
                spec_count_q <= res_step.count;
            end else begin
                spec_ptr_q   <= spec_step.ptr;
                spec_count_q <= spec_step.count;
            end
`endif
            if (res_step.wr) ras_q[res_step.wr_idx] <= branch_source_i + 32'd4;
            ras_ptr_q   <= res_step.ptr;
            ras_count_q <= res_step.count;
        end
    end

    always_comb begin
        next_taken_f_o = 1'b0;
        next_pc_f_o    = pc_f_i + 32'd4;
        if (!rst_i && f_hit) begin
            if (btb_ret_q[f_btb_idx] && !ras_empty) begin
                next_taken_f_o = 1'b1;
                next_pc_f_o    = ras_q[ras_top_ptr];
            end else if (btb_call_q[f_btb_idx] || btb_ret_q[f_btb_idx] || btb_jmp_q[f_btb_idx] ||
                         bht_q[f_bht_idx][1]) begin
                next_taken_f_o = 1'b1;
                next_pc_f_o    = btb_target_q[f_btb_idx];
            end
        end
    end
endmodule

// File: tb/tb_biriscv_branch_predictor.sv
// tb/tb_biriscv_branch_predictor.sv - self-checking bench for biriscv_branch_predictor
module tb_biriscv_branch_predictor;
    logic        clk_i, rst_i;
    logic        branch_request_i, branch_is_taken_i, branch_is_not_taken_i;
    logic [31:0] branch_source_i, branch_pc_i, pc_f_i, next_pc_f_o;
    logic        branch_is_call_i, branch_is_ret_i, branch_is_jmp_i, pc_accept_i, next_taken_f_o;

    int vectors = 0;
    int errors  = 0;

    typedef struct {
        bit        valid;
        bit [31:0] src;
        bit [31:0] tgt;
        bit        call;
        bit        ret;
        bit        jmp;
    } m_btb_t;

    m_btb_t    m_btb [16];
    int        m_bht [64];
    bit [31:0] m_ras [$];
    bit        m_tk;
    bit [31:0] m_pc;

    biriscv_branch_predictor dut (
        .clk_i                 (clk_i),
        .rst_i                 (rst_i),
        .branch_request_i      (branch_request_i),
        .branch_is_taken_i     (branch_is_taken_i),
        .branch_is_not_taken_i (branch_is_not_taken_i),
        .branch_source_i       (branch_source_i),
        .branch_pc_i           (branch_pc_i),
        .branch_is_call_i      (branch_is_call_i),
        .branch_is_ret_i       (branch_is_ret_i),
        .branch_is_jmp_i       (branch_is_jmp_i),
        .pc_f_i                (pc_f_i),
        .pc_accept_i           (pc_accept_i),
        .next_pc_f_o           (next_pc_f_o),
        .next_taken_f_o        (next_taken_f_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic int btb_slot(input bit [31:0] pc);
        return int'((pc / 32'd4) % 32'd16);
    endfunction

    function automatic int bht_slot(input bit [31:0] pc);
        return int'((pc / 32'd4) % 32'd64);
    endfunction

    function automatic void model_reset();
        foreach (m_btb[i]) m_btb[i].valid = 1'b0;
        foreach (m_bht[i]) m_bht[i] = 1;
        m_ras.delete();
    endfunction

    function automatic void model_update(input bit req, input bit tk, input bit ntk, input bit [31:0] src,
                                         input bit [31:0] tgt, input bit call, input bit ret, input bit jmp);
        int b;
        b = bht_slot(src);
        if (!req || tk == ntk) return;
        if (tk) begin
            if (m_bht[b] < 3) m_bht[b]++;
            m_btb[btb_slot(src)] = '{1'b1, src, tgt, call, ret, jmp};
        end else if (m_bht[b] > 0) begin
            m_bht[b]--;
        end
        if (call && ret) begin
            if (m_ras.size() > 0) void'(m_ras.pop_back());
            m_ras.push_back(src + 32'd4);
        end else if (call) begin
            m_ras.push_back(src + 32'd4);
            if (m_ras.size() > 8) void'(m_ras.pop_front());
        end else if (ret && m_ras.size() > 0) begin
            void'(m_ras.pop_back());
        end
    endfunction

    function automatic void model_predict(input bit rst, input bit [31:0] pc, output bit tk, output bit [31:0] npc);
        m_btb_t e;
        tk  = 1'b0;
        npc = pc + 32'd4;
        if (rst) return;
        e = m_btb[btb_slot(pc)];
        if (!e.valid || (e.src / 32'd64) != (pc / 32'd64)) return;
        if (e.ret && m_ras.size() > 0) begin
            tk  = 1'b1;
            npc = m_ras[$];
        end else if (e.call || e.ret || e.jmp || m_bht[bht_slot(pc)] >= 2) begin
            tk  = 1'b1;
            npc = e.tgt;
        end
    endfunction

    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        p = $urandom_range(0, 255) << 2;
        if ($urandom_range(0, 7) == 0) p[31] = 1'b1;
        return p;
    endfunction

    task automatic drive(input logic tk, input logic ntk, input logic [31:0] src, input logic [31:0] tgt,
                         input logic call, input logic ret, input logic jmp);
        branch_request_i      = 1'b1;
        branch_is_taken_i     = tk;
        branch_is_not_taken_i = ntk;
        branch_source_i       = src;
        branch_pc_i           = tgt;
        branch_is_call_i      = call;
        branch_is_ret_i       = ret;
        branch_is_jmp_i       = jmp;
    endtask

    task automatic tick();
        @(posedge clk_i);
        if (rst_i) model_reset();
        else model_update(branch_request_i, branch_is_taken_i, branch_is_not_taken_i, branch_source_i,
                          branch_pc_i, branch_is_call_i, branch_is_ret_i, branch_is_jmp_i);
        #1;
        branch_request_i      = 1'b0;
        branch_is_taken_i     = 1'b0;
        branch_is_not_taken_i = 1'b0;
        branch_is_call_i      = 1'b0;
        branch_is_ret_i       = 1'b0;
        branch_is_jmp_i       = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] pc);
        pc_f_i = pc;
        #1;
        model_predict(rst_i, pc, m_tk, m_pc);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        drive(1'b1, 1'b0, 32'h8000_0000, 32'h0000_1234, 1'b0, 1'b0, 1'b1);
        lookup(32'h8000_0000);
        vectors++;
        if (next_taken_f_o !== 1'b0 || next_pc_f_o !== 32'h8000_0004) begin
            errors++;
            $display("FAIL reset_forced: got %0b/%h, want 0/80000004", next_taken_f_o, next_pc_f_o);
        end
        tick();
        tick();
        rst_i = 1'b0;
        lookup(32'h8000_0000);
        vectors++;
        if (next_taken_f_o !== 1'b0 || next_pc_f_o !== 32'h8000_0004) begin
            errors++;
            $display("FAIL reset_state: got %0b/%h, want 0/80000004", next_taken_f_o, next_pc_f_o);
        end
    endtask

    task automatic test_ignored();
        drive(1'b1, 1'b1, 32'h700, 32'h900, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 32'h700, 32'h900, 1'b0, 1'b0, 1'b1);
        tick();
        lookup(32'h700);
        vectors++;
        if (next_taken_f_o !== 1'b0 || next_pc_f_o !== 32'h704) begin
            errors++;
            $display("FAIL ignored_update: got %0b/%h, want 0/00000704", next_taken_f_o, next_pc_f_o);
        end
    endtask

    task automatic test_cond_training();
        logic [31:0] want [4] = '{32'h200, 32'h200, 32'h200, 32'h104};
        logic        want_tk [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            if (i < 2) drive(1'b1, 1'b0, 32'h100, 32'h200, 1'b0, 1'b0, 1'b0);
            else       drive(1'b0, 1'b1, 32'h100, 32'h104, 1'b0, 1'b0, 1'b0);
            tick();
            lookup(32'h100);
            vectors++;
            if (next_taken_f_o !== want_tk[i] || next_pc_f_o !== want[i]) begin
                errors++;
                $display("FAIL cond_step%0d: got %0b/%h, want %0b/%h", i, next_taken_f_o, next_pc_f_o,
                         want_tk[i], want[i]);
            end
        end
    endtask

    task automatic test_jump();
        drive(1'b1, 1'b0, 32'h40, 32'h1000, 1'b0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 32'h40, 32'h44, 1'b0, 1'b0, 1'b0);
            tick();
        end
        lookup(32'h40);
        vectors++;
        if (next_taken_f_o !== 1'b1 || next_pc_f_o !== 32'h1000) begin
            errors++;
            $display("FAIL jmp_counter0: got %0b/%h, want 1/00001000", next_taken_f_o, next_pc_f_o);
        end
        lookup(32'h100);
        vectors++;
        if (next_taken_f_o !== 1'b0 || next_pc_f_o !== 32'h104) begin
            errors++;
            $display("FAIL jmp_evicts_alias: got %0b/%h, want 0/00000104", next_taken_f_o, next_pc_f_o);
        end
    endtask

    task automatic test_call_ret();
        drive(1'b1, 1'b0, 32'h300, 32'h500, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 32'h520, 32'h304, 1'b0, 1'b1, 1'b0);
        tick();
        lookup(32'h520);
        vectors++;
        if (next_taken_f_o !== 1'b1 || next_pc_f_o !== 32'h304) begin
            errors++;
            $display("FAIL ret_empty_ras: got %0b/%h, want 1/00000304", next_taken_f_o, next_pc_f_o);
        end
        drive(1'b1, 1'b0, 32'h310, 32'h500, 1'b1, 1'b0, 1'b0);
        tick();
        lookup(32'h520);
        vectors++;
        if (next_taken_f_o !== 1'b1 || next_pc_f_o !== 32'h314) begin
            errors++;
            $display("FAIL ret_ras_top: got %0b/%h, want 1/00000314", next_taken_f_o, next_pc_f_o);
        end
        lookup(32'h300);
        vectors++;
        if (next_taken_f_o !== 1'b1 || next_pc_f_o !== 32'h500) begin
            errors++;
            $display("FAIL call_lookup: got %0b/%h, want 1/00000500", next_taken_f_o, next_pc_f_o);
        end
    endtask

    task automatic test_ras_overflow();
        logic [31:0] want;
        drive(1'b1, 1'b0, 32'h604, 32'h9990, 1'b0, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 1'b0, 32'h10 * i, 32'h2000, 1'b1, 1'b0, 1'b0);
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            want = (i < 8) ? 32'h84 - 32'h10 * i : 32'h9990;
            lookup(32'h604);
            vectors++;
            if (next_taken_f_o !== 1'b1 || next_pc_f_o !== want) begin
                errors++;
                $display("FAIL ras_pop%0d: got %0b/%h, want 1/%h", i, next_taken_f_o, next_pc_f_o, want);
            end
            drive(1'b1, 1'b0, 32'h604, 32'h9990, 1'b0, 1'b1, 1'b0);
            tick();
        end
        drive(1'b1, 1'b0, 32'h800, 32'h2000, 1'b1, 1'b0, 1'b0);
        tick();
        lookup(32'h604);
        vectors++;
        if (next_taken_f_o !== 1'b1 || next_pc_f_o !== 32'h804) begin
            errors++;
            $display("FAIL ras_after_underflow: got %0b/%h, want 1/00000804", next_taken_f_o, next_pc_f_o);
        end
        drive(1'b1, 1'b0, 32'h604, 32'h9990, 1'b0, 1'b1, 1'b0);
        tick();
        lookup(32'h604);
        vectors++;
        if (next_taken_f_o !== 1'b1 || next_pc_f_o !== 32'h9990) begin
            errors++;
            $display("FAIL ras_reempty: got %0b/%h, want 1/00009990", next_taken_f_o, next_pc_f_o);
        end
    endtask

    task automatic test_same_cycle_alias();
        drive(1'b1, 1'b0, 32'h100, 32'h200, 1'b0, 1'b0, 1'b0);
        lookup(32'h100);
        vectors++;
        if (next_taken_f_o !== 1'b0 || next_pc_f_o !== 32'h104) begin
            errors++;
            $display("FAIL same_cycle_old: got %0b/%h, want 0/00000104", next_taken_f_o, next_pc_f_o);
        end
        tick();
        lookup(32'h100);
        vectors++;
        if (next_taken_f_o !== 1'b1 || next_pc_f_o !== 32'h200) begin
            errors++;
            $display("FAIL same_cycle_new: got %0b/%h, want 1/00000200", next_taken_f_o, next_pc_f_o);
        end
        drive(1'b1, 1'b0, 32'h140, 32'h3000, 1'b0, 1'b0, 1'b0);
        tick();
        lookup(32'h100);
        vectors++;
        if (next_taken_f_o !== 1'b0 || next_pc_f_o !== 32'h104) begin
            errors++;
            $display("FAIL alias_miss: got %0b/%h, want 0/00000104", next_taken_f_o, next_pc_f_o);
        end
        lookup(32'h140);
        vectors++;
        if (next_taken_f_o !== m_tk || next_pc_f_o !== m_pc) begin
            errors++;
            $display("FAIL alias_new: got %0b/%h, want %0b/%h", next_taken_f_o, next_pc_f_o, m_tk, m_pc);
        end
    endtask

    task automatic test_random();
        logic [31:0] pc, src;
        int          sel;
        logic        tk, ntk;
        for (int n = 0; n < 600; n++) begin
            rst_i       = ($urandom_range(0, 99) == 0);
            pc_accept_i = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) != 0) begin
                sel = $urandom_range(0, 9);
                tk  = (sel < 5) || (sel == 8);
                ntk = (sel >= 5 && sel < 8) || (sel == 8);
                src = rand_pc();
                drive(tk, ntk, src, tk ? ($urandom & 32'hFFFF_FFFC) : src + 32'd4,
                      $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0);
            end
            pc = rand_pc();
            lookup(pc);
            vectors++;
            if (next_taken_f_o !== m_tk || next_pc_f_o !== m_pc) begin
                errors++;
                $display("FAIL random[%0d] pc=%h rst=%0b: got %0b/%h, want %0b/%h", n, pc, rst_i,
                         next_taken_f_o, next_pc_f_o, m_tk, m_pc);
            end
            tick();
        end
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i                 = 1'b1;
        branch_request_i      = 1'b0;
        branch_is_taken_i     = 1'b0;
        branch_is_not_taken_i = 1'b0;
        branch_source_i       = 32'h0;
        branch_pc_i           = 32'h0;
        branch_is_call_i      = 1'b0;
        branch_is_ret_i       = 1'b0;
        branch_is_jmp_i       = 1'b0;
        pc_f_i                = 32'h0;
        pc_accept_i           = 1'b0;
        test_reset();
        test_ignored();
        test_cond_training();
        test_jump();
        test_call_ret();
        test_ras_overflow();
        test_same_cycle_alias();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
